// File: rtl/l1_cache.sv
// l1_cache: direct-mapped, write-through, no-write-allocate L1 data cache.
// A hit read completes in the same cycle. A miss or any store goes out to
// backing memory over a req/ack handshake, and DONE then pulses ready once.
// Optional macro L1_CACHE_STATS_EN adds the hit_count / miss_count outputs.
//
// Handshakes:
//  - Requester side: the request (address, input_data, should_write) is
//    sampled in IDLE. ready=1 marks completion in that cycle. The requester
//    presents its next request on the cycle after ready=1.
//  - Memory side: mem_req/mem_we/mem_addr/mem_wdata are held stable from the
//    cycle after the request until the cycle mem_ack is seen high.
//    mem_ack is a one-cycle pulse, and it is ignored while mem_req=0.
module l1_cache #(
  parameter int NUM_LINES  = 4,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           address,
  input  logic [WORD_WIDTH-1:0] input_data,
  input  logic                  should_write,
  output logic [WORD_WIDTH-1:0] output_data,
  output logic                  ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
`ifdef L1_CACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 32 - IDX_W - 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic [NUM_LINES-1:0]  r_valid;
  logic [TAG_W-1:0]      r_tag  [NUM_LINES];
  logic [WORD_WIDTH-1:0] r_data [NUM_LINES];

  logic [31:0]           r_addr;
  logic [WORD_WIDTH-1:0] r_wdata;
  logic [WORD_WIDTH-1:0] r_result;
  logic                  r_is_write;

  logic [IDX_W-1:0]      w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_hit;
  logic                  w_read_hit;
  logic [IDX_W-1:0]      w_l_idx;
  logic [TAG_W-1:0]      w_l_tag;
  logic                  w_l_hit;
  logic                  w_fetch_ack;
  logic                  w_write_ack;

  // Lookup for the live request (used in IDLE) and for the latched one.
  assign w_idx       = address[IDX_W+1:2];
  assign w_tag       = address[31:IDX_W+2];
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_read_hit  = (r_state == S_IDLE) && !should_write && w_hit;

  assign w_l_idx     = r_addr[IDX_W+1:2];
  assign w_l_tag     = r_addr[31:IDX_W+2];
  assign w_l_hit     = r_valid[w_l_idx] && (r_tag[w_l_idx] == w_l_tag);

  assign w_fetch_ack = (r_state == S_FETCH) && mem_ack;
  assign w_write_ack = (r_state == S_WRITE) && mem_ack;

  // The memory-side outputs come straight from the state and the latched
  // request, so they go to zero at the moment reset is asserted.
  assign mem_req   = (r_state == S_FETCH) || (r_state == S_WRITE);
  assign mem_we    = (r_state == S_WRITE);
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic and the requester-side outputs.
  always_comb begin
    w_next_state = r_state;
    ready        = 1'b0;
    output_data  = '0;
    case (r_state)
      S_IDLE: begin
        if (should_write) begin
          w_next_state = S_WRITE;
        end else if (w_hit) begin
          ready       = 1'b1;
          output_data = r_data[w_idx];
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_FETCH: if (mem_ack) w_next_state = S_DONE;
      S_WRITE: if (mem_ack) w_next_state = S_DONE;
      S_DONE: begin
        ready        = 1'b1;
        output_data  = r_is_write ? '0 : r_result;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Latch the request in IDLE, then set valid and capture read data on a fill.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid    <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_result   <= '0;
      r_is_write <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        if (should_write) begin
          r_addr     <= address;
          r_wdata    <= input_data;
          r_is_write <= 1'b1;
        end else if (!w_hit) begin
          r_addr     <= address;
          r_is_write <= 1'b0;
        end
      end
      if (w_fetch_ack) begin
        r_valid[w_l_idx] <= 1'b1;
        r_result         <= mem_rdata;
      end
    end
  end

  // Tag and data arrays are not reset: a line is only used once its valid bit is set.
  always_ff @(posedge clock) begin
    if (w_fetch_ack) begin
      r_data[w_l_idx] <= mem_rdata;
      r_tag[w_l_idx]  <= w_l_tag;
    end else if (w_write_ack && w_l_hit) begin
      r_data[w_l_idx] <= r_wdata;
    end
  end

`ifdef L1_CACHE_STATS_EN
  // Count read hits in IDLE and misses that start a fill. Stores are not counted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (w_read_hit) hit_count <= hit_count + 32'd1;
      if ((r_state == S_IDLE) && (w_next_state == S_FETCH)) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l1_cache.sv
// Testbench for l1_cache. The reference model keeps, for each line, the full
// word address it holds, and keeps backing memory as an associative array.
// The build can also define L1_CACHE_STATS_EN to test the counters.
module tb_l1_cache;

  localparam int NUM_LINES  = 4;
  localparam int WORD_WIDTH = 32;

  logic                  clock;
  logic                  reset;
  logic [31:0]           address;
  logic [WORD_WIDTH-1:0] input_data;
  logic                  should_write;
  logic [WORD_WIDTH-1:0] output_data;
  logic                  ready;
  logic                  mem_req;
  logic                  mem_we;
  logic [31:0]           mem_addr;
  logic [WORD_WIDTH-1:0] mem_wdata;
  logic [WORD_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;
`ifdef L1_CACHE_STATS_EN
  logic [31:0]           hit_count;
  logic [31:0]           miss_count;
`endif

  int checks;
  int failures;

  // Reference model
  bit                    m_valid [NUM_LINES];
  logic [29:0]           m_waddr [NUM_LINES];
  logic [WORD_WIDTH-1:0] m_data  [NUM_LINES];
  logic [WORD_WIDTH-1:0] m_mem   [int unsigned];
  int unsigned           m_hits;
  int unsigned           m_misses;

  l1_cache #(.NUM_LINES(NUM_LINES), .WORD_WIDTH(WORD_WIDTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .input_data   (input_data),
    .should_write (should_write),
    .output_data  (output_data),
    .ready        (ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
`ifdef L1_CACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void model_clear();
    for (int i = 0; i < NUM_LINES; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endfunction

  // One complete request. Call it 1 time unit after a rising edge; it returns 1 time unit after a rising edge.
  task automatic do_access(input logic [31:0] a, input logic [31:0] d, input logic we, input int dly);
    int                    idx;
    bit                    hit;
    logic [WORD_WIDTH-1:0] rdata;
    logic [WORD_WIDTH-1:0] exp;
    idx          = int'((a >> 2) % NUM_LINES);
    hit          = m_valid[idx] && (m_waddr[idx] == a[31:2]);
    address      = a;
    input_data   = d;
    should_write = we;
    #1;
    if (!we && hit) begin
      m_hits++;
      checks++;
      if (ready !== 1'b1 || output_data !== m_data[idx] || mem_req !== 1'b0) begin
        failures++;
        $display("FAIL read_hit addr=%h: ready=%b data=%h mem_req=%b, expected ready=1 data=%h mem_req=0",
                 a, ready, output_data, mem_req, m_data[idx]);
      end
      @(posedge clock); #1;
      return;
    end
    checks++;
    if (ready !== 1'b0 || output_data !== '0) begin
      failures++;
      $display("FAIL req_idle addr=%h: ready=%b data=%h, expected ready=0 data=0", a, ready, output_data);
    end
    if (!we) m_misses++;
    if (m_mem.exists(a[31:2])) rdata = m_mem[a[31:2]];
    else begin
      rdata = $urandom;
      m_mem[a[31:2]] = rdata;
    end
    for (int c = 0; c <= dly; c++) begin
      @(posedge clock); #1;
      mem_ack      = (c == dly);
      mem_rdata    = (c == dly) ? rdata : $urandom;
      address      = $urandom;
      input_data   = $urandom;
      should_write = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (mem_req !== 1'b1 || mem_we !== we || mem_addr !== a || (we && mem_wdata !== d) ||
          ready !== 1'b0 || output_data !== '0) begin
        failures++;
        $display("FAIL mem_phase addr=%h cyc=%0d: req=%b we=%b maddr=%h wdata=%h ready=%b, expected req=1 we=%b maddr=%h wdata=%h ready=0",
                 a, c, mem_req, mem_we, mem_addr, mem_wdata, ready, we, a, d);
      end
    end
    @(posedge clock); #1;
    mem_ack = 1'b0;
    if (we) begin
      m_mem[a[31:2]] = d;
      if (hit) m_data[idx] = d;
      exp = '0;
    end else begin
      m_valid[idx] = 1'b1;
      m_waddr[idx] = a[31:2];
      m_data[idx]  = rdata;
      exp          = rdata;
    end
    #1;
    checks++;
    if (ready !== 1'b1 || output_data !== exp || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL done addr=%h we=%b: ready=%b data=%h mem_req=%b, expected ready=1 data=%h mem_req=0",
               a, we, ready, output_data, mem_req, exp);
    end
    @(posedge clock); #1;
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL after_done addr=%h: mem_req=%b, expected 0", a, mem_req);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (ready !== 1'b0 || output_data !== '0 || mem_req !== 1'b0 || mem_we !== 1'b0 ||
        mem_addr !== '0 || mem_wdata !== '0) begin
      failures++;
      $display("FAIL %s: ready=%b data=%h req=%b we=%b maddr=%h wdata=%h, expected all 0",
               name, ready, output_data, mem_req, mem_we, mem_addr, mem_wdata);
    end
`ifdef L1_CACHE_STATS_EN
    checks++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      failures++;
      $display("FAIL %s_stats: hits=%0d misses=%0d, expected 0 0", name, hit_count, miss_count);
    end
`endif
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    address      = 32'h0;
    input_data   = 32'h0;
    should_write = 1'b0;
    mem_ack      = 1'b0;
    mem_rdata    = 32'h0;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("reset_state");
    reset = 1'b1;
  endtask

  task automatic test_read_miss();
    m_mem[32'h10 >> 2] = 32'hDEADBEEF;
    do_access(32'h10, 32'h0, 1'b0, 2);
  endtask

  task automatic test_read_hit();
    do_access(32'h10, 32'h0, 1'b0, 0);
    checks++;
    if (m_data[0] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL read_hit_value: model line0=%h, expected deadbeef", m_data[0]);
    end
  endtask

  task automatic test_write_hit();
    do_access(32'h10, 32'h12345678, 1'b1, 1);
    do_access(32'h10, 32'h0, 1'b0, 0);
  endtask

  task automatic test_write_no_allocate();
    do_access(32'h20, 32'hCAFEF00D, 1'b1, 0);
    do_access(32'h10, 32'h0, 1'b0, 0);
    do_access(32'h20, 32'h0, 1'b0, 1);
  endtask

  task automatic test_replace();
    do_access(32'h50, 32'h0, 1'b0, 0);
    do_access(32'h10, 32'h0, 1'b0, 3);
  endtask

  task automatic test_reset_mid_fetch();
    address      = 32'h14;
    should_write = 1'b0;
    @(posedge clock); #1;
    address = 32'h14;
    #1;
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL mid_fetch_req: mem_req=%b, expected 1", mem_req);
    end
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("reset_mid_fetch");
    model_clear();
    @(posedge clock); #1;
    check_reset_outputs("reset_held");
    mem_ack   = 1'b1;
    mem_rdata = 32'hBADBAD00;
    reset     = 1'b1;
    do_access(32'h10, 32'h0, 1'b0, 1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < NUM_LINES; i++) do_access(32'(i * 4), 32'h0, 1'b0, 0);
    for (int i = 0; i < 2 * NUM_LINES; i++) do_access(32'((i % NUM_LINES) * 4), 32'h0, 1'b0, 0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 60; n++) begin
      a = 32'($urandom_range(0, 15)) << 2;
      do_access(a, $urandom, 1'($urandom_range(0, 2) == 0), $urandom_range(0, 3));
    end
`ifdef L1_CACHE_STATS_EN
    checks++;
    if (hit_count !== m_hits || miss_count !== m_misses) begin
      failures++;
      $display("FAIL stats: hits=%0d misses=%0d, expected %0d %0d", hit_count, miss_count, m_hits, m_misses);
    end
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    #1;
    test_read_miss();
    test_read_hit();
    test_write_hit();
    test_write_no_allocate();
    test_replace();
    test_reset_mid_fetch();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
